// File: rtl/dds_ctrl_pkg.sv
// Shared types and default widths for the DDS tuning-ramp control path.
// Widths match the DDS accumulator/tune ports and the DDS testbenches.
package dds_ctrl_pkg;
    localparam int TUNE_BITS = 44;
    localparam int STEP_BITS = 32;
    localparam int DIV_BITS  = 16;

    typedef enum logic [1:0] {IDLE, LOAD, RAMP, DONE} t_ramp_state;
    typedef enum logic {DIR_UP, DIR_DOWN} t_ramp_dir;
endpackage

// File: rtl/dds_ramp_stepper.sv
// Clamped next tune word for one ramp step; purely combinational, zero latency.
// No backpressure: the caller decides when to register the result.
module dds_ramp_stepper
    import dds_ctrl_pkg::*;
#(
    parameter int g_tune_bits = TUNE_BITS
) (
    input  logic [g_tune_bits-1:0] cur,
    input  logic [g_tune_bits-1:0] step,
    input  logic [g_tune_bits-1:0] target,
    input  t_ramp_dir              dir,
    output logic [g_tune_bits-1:0] next,
    output logic                   reached
);
    logic [g_tune_bits:0] sum;
    logic [g_tune_bits:0] diff;

    assign sum  = {1'b0, cur} + {1'b0, step};
    assign diff = {1'b0, cur} - {1'b0, step};

    // Anything that overshoots, wraps or uses a zero step lands exactly on target.
    always_comb begin
        next = target;
        if (step != '0) begin
            if (dir == DIR_UP) begin
                if (!sum[g_tune_bits] && (sum[g_tune_bits-1:0] < target))
                    next = sum[g_tune_bits-1:0];
            end else begin
                if (!diff[g_tune_bits] && (diff[g_tune_bits-1:0] > target))
                    next = diff[g_tune_bits-1:0];
            end
        end
    end

    assign reached = (next == target);
endmodule

// File: rtl/dds_tune_ramp_ctrl.sv
// Linear tune-word ramp sequencer for one DDS channel; start word one cycle after go, then a step every div+1 cycles.
// No backpressure; abort returns to idle holding tune_o. Phase preset enabled by DDS_RAMP_PHASE_SYNC_EN.
module dds_tune_ramp_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int g_tune_bits = TUNE_BITS,
    parameter int g_step_bits = STEP_BITS,
    parameter int g_div_bits  = DIV_BITS
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [g_tune_bits-1:0] cfg_start_i,
    input  logic [g_tune_bits-1:0] cfg_target_i,
    input  logic [g_step_bits-1:0] cfg_step_i,
    input  logic [g_div_bits-1:0]  cfg_div_i,
    input  logic [g_tune_bits-1:0] cfg_acc_i,
    input  logic                   cmd_go_i,
    input  logic                   cmd_abort_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [g_tune_bits-1:0] tune_o,
    output logic                   tune_load_o,
    output logic [g_tune_bits-1:0] acc_o,
    output logic                   acc_load_o
);
    localparam logic [g_div_bits-1:0] DIV_ONE = {{(g_div_bits-1){1'b0}}, 1'b1};

    t_ramp_state            state_q, state_nxt;
    t_ramp_dir              dir_q;
    logic [g_tune_bits-1:0] start_q, target_q, tune_q, tune_nxt, step_ext, step_val;
    logic [g_step_bits-1:0] step_q;
    logic [g_div_bits-1:0]  div_q, div_cnt_q, div_cnt_nxt;
    logic                   tune_load_q, tune_load_nxt;
    logic                   busy_q, busy_nxt, done_q, done_nxt;
    logic                   cfg_latch, step_reached;

    assign step_ext = {{(g_tune_bits-g_step_bits){1'b0}}, step_q};

    dds_ramp_stepper #(.g_tune_bits(g_tune_bits)) u_stepper (
        .cur     (tune_q),
        .step    (step_ext),
        .target  (target_q),
        .dir     (dir_q),
        .next    (step_val),
        .reached (step_reached)
    );

    always_comb begin
        state_nxt     = state_q;
        tune_nxt      = tune_q;
        tune_load_nxt = 1'b0;
        done_nxt      = 1'b0;
        busy_nxt      = busy_q;
        div_cnt_nxt   = div_cnt_q;
        cfg_latch     = 1'b0;
        if ((state_q != IDLE) && cmd_abort_i) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_nxt = 1'b0;
                    if (cmd_go_i && !cmd_abort_i) begin
                        cfg_latch = 1'b1;
                        busy_nxt  = 1'b1;
                        state_nxt = LOAD;
                    end
                end
                LOAD: begin
                    tune_nxt      = start_q;
                    tune_load_nxt = 1'b1;
                    div_cnt_nxt   = div_q;
                    state_nxt     = (start_q == target_q) ? DONE : RAMP;
                end
                RAMP: begin
                    if (div_cnt_q != '0) begin
                        div_cnt_nxt = div_cnt_q - DIV_ONE;
                    end else begin
                        tune_nxt      = step_val;
                        tune_load_nxt = 1'b1;
                        div_cnt_nxt   = div_q;
                        if (step_reached)
                            state_nxt = DONE;
                    end
                end
                DONE: begin
                    // busy stays up through the done pulse and drops on the following cycle
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            tune_q      <= '0;
            tune_load_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_cnt_q   <= '0;
        end else begin
            state_q     <= state_nxt;
            tune_q      <= tune_nxt;
            tune_load_q <= tune_load_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
            div_cnt_q   <= div_cnt_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            start_q  <= '0;
            target_q <= '0;
            step_q   <= '0;
            div_q    <= '0;
            dir_q    <= DIR_UP;
        end else if (cfg_latch) begin
            start_q  <= cfg_start_i;
            target_q <= cfg_target_i;
            step_q   <= cfg_step_i;
            div_q    <= cfg_div_i;
            dir_q    <= (cfg_target_i >= cfg_start_i) ? DIR_UP : DIR_DOWN;
        end
    end

    assign tune_o      = tune_q;
    assign tune_load_o = tune_load_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

`ifdef DDS_RAMP_PHASE_SYNC_EN
    logic [g_tune_bits-1:0] acc_cfg_q, acc_q;
    logic                   acc_load_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_cfg_q  <= '0;
            acc_q      <= '0;
            acc_load_q <= 1'b0;
        end else begin
            acc_load_q <= 1'b0;
            if (cfg_latch)
                acc_cfg_q <= cfg_acc_i;
            if ((state_q == LOAD) && !cmd_abort_i) begin
                acc_q      <= acc_cfg_q;
                acc_load_q <= 1'b1;
            end
        end
    end

    assign acc_o      = acc_q;
    assign acc_load_o = acc_load_q;
`else
    logic unused_acc;
    assign unused_acc = ^cfg_acc_i;
    assign acc_o      = '0;
    assign acc_load_o = 1'b0;
`endif
endmodule

// File: tb/tb_dds_tune_ramp_ctrl.sv
// Directed bench for dds_tune_ramp_ctrl: ramps, clamps, degenerate cases, abort/go collisions, reset.
module tb_dds_tune_ramp_ctrl;
    localparam int TW = 44;
    localparam int SW = 32;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [TW-1:0] cfg_start, cfg_target, cfg_acc;
    logic [SW-1:0] cfg_step;
    logic [DW-1:0] cfg_div;
    logic          cmd_go, cmd_abort;
    logic          busy, done, tune_load, acc_load;
    logic [TW-1:0] tune, acc;

    int checks = 0;
    int errors = 0;

    logic          cap_load [32];
    logic          cap_done [32];
    logic          cap_busy [32];
    logic          cap_accl [32];
    logic [TW-1:0] cap_tune [32];
    logic [TW-1:0] cap_acc  [32];

    always #5 clk = ~clk;

    dds_tune_ramp_ctrl dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cfg_start_i  (cfg_start),
        .cfg_target_i (cfg_target),
        .cfg_step_i   (cfg_step),
        .cfg_div_i    (cfg_div),
        .cfg_acc_i    (cfg_acc),
        .cmd_go_i     (cmd_go),
        .cmd_abort_i  (cmd_abort),
        .busy_o       (busy),
        .done_o       (done),
        .tune_o       (tune),
        .tune_load_o  (tune_load),
        .acc_o        (acc),
        .acc_load_o   (acc_load)
    );

    task automatic start_ramp(input logic [TW-1:0] s, input logic [TW-1:0] t,
                              input logic [SW-1:0] st, input logic [DW-1:0] d,
                              input logic [TW-1:0] a);
        cfg_start = s; cfg_target = t; cfg_step = st; cfg_div = d; cfg_acc = a;
        cmd_go = 1'b1;
        @(posedge clk); #1;
        cmd_go = 1'b0;
    endtask

    task automatic capture(input int n, input int go_at, input int abort_at);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            cap_load[c] = tune_load; cap_tune[c] = tune; cap_done[c] = done;
            cap_busy[c] = busy;      cap_accl[c] = acc_load; cap_acc[c] = acc;
            cmd_go    = (c == go_at);
            cmd_abort = (c == abort_at);
        end
        cmd_go = 1'b0; cmd_abort = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({tune_load, busy, done, acc_load} !== 4'b0000 || tune !== '0 || acc !== '0) begin
            errors++;
            $display("FAIL reset_state: load=%b busy=%b done=%b accl=%b tune=%0d acc=%0d, required all 0",
                     tune_load, busy, done, acc_load, tune, acc);
        end
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(2);
        checks++;
        if (busy !== 1'b0 || tune_load !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b load=%b, required 0 0", busy, tune_load);
        end
    endtask

    task automatic test_up_ramp();
        logic          el, ed, eb;
        logic [TW-1:0] et;
        start_ramp(100, 130, 10, 2, 0);
        capture(13, -1, -1);
        for (int c = 0; c < 13; c++) begin
            el = (c % 3 == 0) && (c <= 9);
            ed = (c == 10);
            eb = (c <= 10);
            et = TW'(100 + 10 * (c / 3));
            checks++;
            if (cap_load[c] !== el || (el && cap_tune[c] !== et)) begin
                errors++;
                $display("FAIL up_ramp_load c=%0d: load=%b tune=%0d, required load=%b tune=%0d",
                         c, cap_load[c], cap_tune[c], el, et);
            end
            checks++;
            if (cap_done[c] !== ed || cap_busy[c] !== eb) begin
                errors++;
                $display("FAIL up_ramp_status c=%0d: done=%b busy=%b, required done=%b busy=%b",
                         c, cap_done[c], cap_busy[c], ed, eb);
            end
        end
        checks++;
        if (cap_tune[12] !== 130) begin
            errors++;
            $display("FAIL up_ramp_hold: tune=%0d, required 130", cap_tune[12]);
        end
    endtask

    task automatic test_down_clamp();
        logic [TW-1:0] exp_t [4];
        exp_t[0] = 1000; exp_t[1] = 990; exp_t[2] = 980; exp_t[3] = 975;
        start_ramp(1000, 975, 10, 0, 0);
        capture(7, -1, -1);
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (cap_load[c] !== (c < 4) || (c < 4 && cap_tune[c] !== exp_t[c])) begin
                errors++;
                $display("FAIL down_clamp c=%0d: load=%b tune=%0d, required load=%b tune=%0d",
                         c, cap_load[c], cap_tune[c], (c < 4), (c < 4) ? exp_t[c] : cap_tune[c]);
            end
            checks++;
            if (cap_done[c] !== (c == 4)) begin
                errors++;
                $display("FAIL down_clamp_done c=%0d: done=%b, required %b", c, cap_done[c], (c == 4));
            end
        end
    endtask

    task automatic test_wrap_guard();
        logic [TW-1:0] top;
        top = '1;
        start_ramp(top - 4, top, 16, 0, 0);
        capture(5, -1, -1);
        checks++;
        if (cap_load[0] !== 1'b1 || cap_tune[0] !== top - 4) begin
            errors++;
            $display("FAIL wrap_start: load=%b tune=%h, required 1 %h", cap_load[0], cap_tune[0], top - 4);
        end
        checks++;
        if (cap_load[1] !== 1'b1 || cap_tune[1] !== top) begin
            errors++;
            $display("FAIL wrap_clamp: load=%b tune=%h, required 1 %h", cap_load[1], cap_tune[1], top);
        end
        checks++;
        if (cap_done[2] !== 1'b1 || cap_load[2] !== 1'b0 || cap_load[3] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: done=%b load2=%b load3=%b, required 1 0 0",
                     cap_done[2], cap_load[2], cap_load[3]);
        end
    endtask

    task automatic test_degenerate();
        start_ramp(500, 500, 10, 3, 0);
        capture(5, -1, -1);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (cap_load[c] !== (c == 0) || cap_done[c] !== (c == 1) || cap_tune[c] !== 500) begin
                errors++;
                $display("FAIL equal_start_target c=%0d: load=%b done=%b tune=%0d, required %b %b 500",
                         c, cap_load[c], cap_done[c], cap_tune[c], (c == 0), (c == 1));
            end
        end
        start_ramp(0, 9, 0, 0, 0);
        capture(5, -1, -1);
        checks++;
        if (cap_load[0] !== 1'b1 || cap_tune[0] !== 0 || cap_load[1] !== 1'b1 || cap_tune[1] !== 9) begin
            errors++;
            $display("FAIL zero_step: loads=%b,%b tunes=%0d,%0d, required 1,1 0,9",
                     cap_load[0], cap_load[1], cap_tune[0], cap_tune[1]);
        end
        checks++;
        if (cap_done[2] !== 1'b1 || cap_load[2] !== 1'b0 || cap_load[3] !== 1'b0 || cap_busy[4] !== 1'b0) begin
            errors++;
            $display("FAIL zero_step_done: done=%b load=%b,%b busy4=%b, required 1 0,0 0",
                     cap_done[2], cap_load[2], cap_load[3], cap_busy[4]);
        end
    endtask

    task automatic test_abort_go();
        start_ramp(100, 130, 10, 2, 0);
        capture(16, -1, 3);
        checks++;
        if (cap_load[3] !== 1'b1 || cap_tune[3] !== 110 || cap_busy[3] !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: load=%b tune=%0d busy=%b, required 1 110 1",
                     cap_load[3], cap_tune[3], cap_busy[3]);
        end
        for (int c = 4; c < 16; c++) begin
            checks++;
            if (cap_load[c] !== 1'b0 || cap_done[c] !== 1'b0 || cap_busy[c] !== 1'b0 || cap_tune[c] !== 110) begin
                errors++;
                $display("FAIL abort_post c=%0d: load=%b done=%b busy=%b tune=%0d, required 0 0 0 110",
                         c, cap_load[c], cap_done[c], cap_busy[c], cap_tune[c]);
            end
        end

        start_ramp(200, 230, 10, 2, 0);
        cfg_start = 7; cfg_target = 3; cfg_step = 1; cfg_div = 0;
        capture(16, 1, -1);
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (cap_load[c] !== ((c % 3 == 0) && (c <= 9)) ||
                (cap_load[c] && cap_tune[c] !== TW'(200 + 10 * (c / 3))) || cap_done[c] !== (c == 10)) begin
                errors++;
                $display("FAIL go_while_busy c=%0d: load=%b tune=%0d done=%b, required load=%b tune=%0d done=%b",
                         c, cap_load[c], cap_tune[c], cap_done[c], ((c % 3 == 0) && (c <= 9)),
                         200 + 10 * (c / 3), (c == 10));
            end
        end

        cfg_start = 50; cfg_target = 60; cfg_step = 5; cfg_div = 0;
        cmd_go = 1'b1; cmd_abort = 1'b1;
        capture(5, -1, -1);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (cap_load[c] !== 1'b0 || cap_busy[c] !== 1'b0 || cap_tune[c] !== 230) begin
                errors++;
                $display("FAIL go_abort_idle c=%0d: load=%b busy=%b tune=%0d, required 0 0 230",
                         c, cap_load[c], cap_busy[c], cap_tune[c]);
            end
        end
    endtask

    task automatic test_reset_mid_ramp();
        start_ramp(100, 130, 10, 2, 0);
        capture(4, -1, -1);
        checks++;
        if (cap_load[3] !== 1'b1 || cap_tune[3] !== 110) begin
            errors++;
            $display("FAIL reset_mid_pre: load=%b tune=%0d, required 1 110", cap_load[3], cap_tune[3]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tune !== '0 || tune_load !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || acc_load !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: tune=%0d load=%b busy=%b done=%b accl=%b, required all 0",
                     tune, tune_load, busy, done, acc_load);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        capture(12, -1, -1);
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (cap_load[c] !== 1'b0 || cap_done[c] !== 1'b0 || cap_tune[c] !== 0) begin
                errors++;
                $display("FAIL reset_mid_post c=%0d: load=%b done=%b tune=%0d, required 0 0 0",
                         c, cap_load[c], cap_done[c], cap_tune[c]);
            end
        end
    endtask

    task automatic test_phase_sync();
        start_ramp(100, 130, 10, 2, 'h123);
        capture(12, -1, -1);
        for (int c = 0; c < 12; c++) begin
            checks++;
`ifdef DDS_RAMP_PHASE_SYNC_EN
            if (cap_accl[c] !== (c == 0) || cap_acc[c] !== 'h123 || (c == 0 && cap_load[c] !== 1'b1)) begin
                errors++;
                $display("FAIL phase_sync c=%0d: accl=%b acc=%h load=%b, required accl=%b acc=123",
                         c, cap_accl[c], cap_acc[c], cap_load[c], (c == 0));
            end
`else
            if (cap_accl[c] !== 1'b0 || cap_acc[c] !== '0) begin
                errors++;
                $display("FAIL phase_off c=%0d: accl=%b acc=%h, required 0 0", c, cap_accl[c], cap_acc[c]);
            end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_start = '0; cfg_target = '0; cfg_step = '0; cfg_div = '0; cfg_acc = '0;
        cmd_go = 1'b0; cmd_abort = 1'b0;
        test_reset();
        test_up_ramp();
        idle_cycles(2);
        test_down_clamp();
        idle_cycles(2);
        test_wrap_guard();
        idle_cycles(2);
        test_degenerate();
        idle_cycles(2);
        test_abort_go();
        idle_cycles(2);
        test_reset_mid_ramp();
        idle_cycles(2);
        test_phase_sync();
        idle_cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
